matrix_result_streamer: RTL and testbench

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

---
 rtl/npu_pkg.sv | 21 ++
 rtl/matrix_result_streamer.sv | 128 ++++++++++++
 tb/tb_matrix_result_streamer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// npu_pkg
// Shared definitions for the NPU result path: default accumulator width,
// the streamer state encoding and the legality check for the matrix
// dimension.
// Ports: none (package).
package npu_pkg;

  localparam int ACC_W_DEFAULT = 32;
  localparam int N_MIN         = 3;
  localparam int N_MAX         = 256;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

  function automatic logic n_legal(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

endpackage

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
// Captures a complete N x N result matrix from the systolic array on a
// single-cycle pulse and streams it out one row per beat over a
// valid/ready interface.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | no matrix held, outputs quiet, waiting for i_validResult
// ST_STREAM | matrix held, row row_q presented until accepted
//
// Ports:
//   i_clk, i_arst_n   clock, asynchronous active-low reset
//   i_c               full result matrix, sampled when i_validResult=1
//   i_validResult     capture pulse
//   o_rowData         row row_q of the held matrix (0 when idle)
//   o_rowIdx          index of the row on o_rowData
//   o_valid, i_ready  beat handshake
//   o_last            final row of the matrix
//   o_busy            a captured matrix is not fully drained
//   o_overrun         sticky: a capture pulse was dropped
//   i_clearOverrun    synchronous clear of o_overrun
module matrix_result_streamer
  import npu_pkg::*;
#(
  parameter int N     = 16,
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic                            i_clk,
  input  logic                            i_arst_n,
  input  logic [N-1:0][N-1:0][ACC_W-1:0]  i_c,
  input  logic                            i_validResult,
  output logic [N-1:0][ACC_W-1:0]         o_rowData,
  output logic [$clog2(N)-1:0]            o_rowIdx,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_last,
  output logic                            o_busy,
  output logic                            o_overrun,
  input  logic                            i_clearOverrun
);

  localparam int ROW_W = $clog2(N);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

  if (!n_legal(N)) begin : g_bad_n
    $error("matrix_result_streamer: N=%0d outside legal range 3..256", N);
  end

  stream_state_e                  state_q;
  stream_state_e                  state_d;
  logic [ROW_W-1:0]               row_q;
  logic [N-1:0][N-1:0][ACC_W-1:0] buf_q;
  logic                           overrun_q;

  logic streaming;
  logic accept;
  logic done;
  logic capture;
  logic drop;

  assign streaming = (state_q == ST_STREAM);
  assign accept    = streaming & i_ready;
  assign done      = accept & (row_q == LAST_ROW);
  // A pulse lands either when idle or exactly as the last row leaves;
  // the latter chains straight into the new matrix with no bubble.
  assign capture   = i_validResult & (~streaming | done);
  assign drop      = i_validResult & ~capture;

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_validResult) state_d = ST_STREAM;
      ST_STREAM: if (done && !i_validResult) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs; data is forced to zero while idle so nothing stale (or
  // unreset buffer content) is ever visible.
  always_comb begin
    o_valid   = streaming;
    o_busy    = streaming;
    o_rowIdx  = row_q;
    o_last    = streaming && (row_q == LAST_ROW);
    o_rowData = streaming ? buf_q[row_q] : '0;
    o_overrun = overrun_q;
  end

  // Row counter and sticky overrun flag
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      row_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (capture) begin
        row_q <= '0;
      end else if (accept) begin
        row_q <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end

      // A new drop takes priority over a same-cycle clear.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (i_clearOverrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Matrix buffer: contents are don't-care until the first capture, so it
  // carries no reset.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      buf_q <= i_c;
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer
// Scoreboard bench for matrix_result_streamer at N=4, ACC_W=32. The
// stimulus process keeps a reference model (rows still owed, sticky
// overrun) and pushes every row it expects into a queue; a separate
// monitor pops and compares whenever a beat is presented.
module tb_matrix_result_streamer;

  localparam int N     = 4;
  localparam int ACC_W = 32;
  localparam int RW    = 2;

  typedef logic [N-1:0][N-1:0][ACC_W-1:0] mat_t;
  typedef logic [N-1:0][ACC_W-1:0]        row_t;

  typedef struct {
    logic [RW-1:0] idx;
    row_t          data;
    logic          last;
  } beat_t;

  logic          i_clk = 1'b0;
  logic          i_arst_n;
  mat_t          i_c;
  logic          i_validResult;
  row_t          o_rowData;
  logic [RW-1:0] o_rowIdx;
  logic          o_valid;
  logic          i_ready;
  logic          o_last;
  logic          o_busy;
  logic          o_overrun;
  logic          i_clearOverrun;

  matrix_result_streamer #(.N(N), .ACC_W(ACC_W)) dut (
    .i_clk          (i_clk),
    .i_arst_n       (i_arst_n),
    .i_c            (i_c),
    .i_validResult  (i_validResult),
    .o_rowData      (o_rowData),
    .o_rowIdx       (o_rowIdx),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_last         (o_last),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun),
    .i_clearOverrun (i_clearOverrun)
  );

  always #5 i_clk = ~i_clk;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  int    remaining = 0;   // rows of the held matrix not yet accepted
  logic  exp_ovr = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any presented beat must equal the oldest owed row; it is
  // retired only when accepted, so stalls also check stability.
  always @(negedge i_clk) begin
    if (i_arst_n && o_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=idx%0d required=none t=%0t", o_rowIdx, $time);
      end else begin
        chk("beat_idx",  128'(o_rowIdx),  128'(sb[0].idx));
        chk("beat_data", 128'(o_rowData), 128'(sb[0].data));
        chk("beat_last", 128'(o_last),    128'(sb[0].last));
        if (i_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic check_outputs();
    chk("valid",   128'(o_valid),   128'(remaining > 0));
    chk("busy",    128'(o_busy),    128'(remaining > 0));
    chk("overrun", 128'(o_overrun), 128'(exp_ovr));
    if (remaining == 0) begin
      chk("idle_data", 128'(o_rowData), 128'(0));
      chk("idle_idx",  128'(o_rowIdx),  128'(0));
      chk("idle_last", 128'(o_last),    128'(0));
    end
  endtask

  // One clock of stimulus: called at posedge+1, checks what the last edge
  // produced, drives inputs for the next edge and advances the model.
  task automatic step(input logic pulse, input logic rdy, input logic clr, input mat_t m);
    logic accept, takes;
    check_outputs();
    i_validResult  = pulse;
    i_ready        = rdy;
    i_clearOverrun = clr;
    i_c            = m;
    accept = (remaining > 0) && rdy;
    takes  = pulse && (remaining == 0 || (remaining == 1 && accept));
    if (accept) remaining--;
    if (takes) begin
      for (int r = 0; r < N; r++) begin
        beat_t b;
        b.idx  = RW'(r);
        b.data = m[r];
        b.last = (r == N - 1);
        sb.push_back(b);
      end
      remaining = N;
    end
    if (pulse && !takes) exp_ovr = 1'b1;
    else if (clr)        exp_ovr = 1'b0;
    @(posedge i_clk);
    #1;
    i_validResult  = 1'b0;
    i_clearOverrun = 1'b0;
  endtask

  task automatic idle_steps(input int n, input logic rdy);
    mat_t z = '0;
    for (int k = 0; k < n; k++) step(1'b0, rdy, 1'b0, z);
  endtask

  function automatic mat_t pattern_mat();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        m[r][j] = 32'(16 * r + j);
    return m;
  endfunction

  function automatic mat_t fill_mat(input logic [31:0] v);
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        m[r][j] = v;
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        m[r][j] = $urandom;
    return m;
  endfunction

  task automatic drain();
    int guard = 0;
    while (remaining > 0 && guard < 4 * N) begin
      idle_steps(1, 1'b1);
      guard++;
    end
    if (remaining > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", remaining);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mat_t pat, ones, ext, m2;
    pat  = pattern_mat();
    ones = fill_mat(32'hFFFF_FFFF);
    ext  = pattern_mat();
    ext[0][0] = 32'h7FFF_FFFF;
    ext[3][3] = 32'h8000_0000;

    i_arst_n = 1'b0;
    i_c = '0;
    i_validResult = 1'b0;
    i_ready = 1'b0;
    i_clearOverrun = 1'b0;
    #3;
    chk("rst_valid",   128'(o_valid),   128'(0));
    chk("rst_busy",    128'(o_busy),    128'(0));
    chk("rst_last",    128'(o_last),    128'(0));
    chk("rst_overrun", 128'(o_overrun), 128'(0));
    chk("rst_idx",     128'(o_rowIdx),  128'(0));
    chk("rst_data",    128'(o_rowData), 128'(0));
    #9;
    i_arst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Full-rate drain, latency 1, idle afterwards.
    step(1'b1, 1'b1, 1'b0, pat);
    idle_steps(N + 2, 1'b1);

    // Ready pattern 1,0,0,1,... with stalls.
    step(1'b1, 1'b0, 1'b0, pat);
    for (int k = 0; k < 4 * N; k++) begin
      mat_t z = '0;
      step(1'b0, (k % 3) == 0, 1'b0, z);
    end
    drain();

    // Overrun while row 1 pending, then clear.
    step(1'b1, 1'b0, 1'b0, pat);
    idle_steps(1, 1'b1);
    step(1'b1, 1'b0, 1'b0, ones);
    idle_steps(1, 1'b0);
    drain();
    idle_steps(1, 1'b0);
    step(1'b0, 1'b0, 1'b1, ones);
    idle_steps(1, 1'b0);

    // Clear and a new overrun together: overrun must win.
    step(1'b1, 1'b0, 1'b0, pat);
    step(1'b1, 1'b0, 1'b1, ones);
    idle_steps(1, 1'b0);
    drain();
    step(1'b0, 1'b0, 1'b1, ones);

    // Back-to-back capture on the accepted last row.
    step(1'b1, 1'b1, 1'b0, pat);
    idle_steps(N - 1, 1'b1);
    step(1'b1, 1'b1, 1'b0, ones);
    drain();
    idle_steps(1, 1'b1);

    // Reset during row 2.
    step(1'b1, 1'b1, 1'b0, pat);
    idle_steps(2, 1'b1);
    i_arst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(o_valid),   128'(0));
    chk("arst_data",  128'(o_rowData), 128'(0));
    chk("arst_last",  128'(o_last),    128'(0));
    sb.delete();
    remaining = 0;
    exp_ovr = 1'b0;
    @(posedge i_clk);
    #2;
    i_arst_n = 1'b1;
    @(posedge i_clk);
    #1;
    idle_steps(3, 1'b1);
    m2 = rand_mat();
    step(1'b1, 1'b1, 1'b0, m2);
    drain();
    idle_steps(1, 1'b1);

    // Signed extremes pass bit-exact.
    step(1'b1, 1'b1, 1'b0, ext);
    drain();
    idle_steps(1, 1'b1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 9) == 0), rand_mat());
    end
    drain();
    idle_steps(2, 1'b1);
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
